// File: rtl/keypad_scan4x4_pkg.sv
// keypad_scan4x4_pkg
//   Shared definitions for the 4x4 keypad scanner: FSM state encoding,
//   status-word bit positions and the active-low one-hot column decode.
//   The column decode is also usable by the 7-segment display select logic.
package keypad_scan4x4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_REL_DB   = 2'd3
    } kp_state_e;

    // Status word bit positions
    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned OVR_BIT   = 30;
    localparam int unsigned MULTI_BIT = 29;
    localparam int unsigned PRESS_BIT = 28;

    // Active-low one-hot column drive patterns
    localparam logic [3:0] COL_SEL0 = 4'b1110;
    localparam logic [3:0] COL_SEL1 = 4'b1101;
    localparam logic [3:0] COL_SEL2 = 4'b1011;
    localparam logic [3:0] COL_SEL3 = 4'b0111;

    function automatic logic [3:0] col_decode(input logic [1:0] col);
        logic [3:0] sel;
        case (col)
            2'd0:    sel = COL_SEL0;
            2'd1:    sel = COL_SEL1;
            2'd2:    sel = COL_SEL2;
            default: sel = COL_SEL3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/keypad_scan4x4_prio16.sv
// keypad_prio16
//   Combinational lowest-set-bit encoder over a 16-bit key frame.
//   Ports:
//     vec_i   [15:0] frame, bit n = key index n
//     idx_o   [3:0]  index of the lowest set bit (0 when none set)
//     any_o          at least one bit set
//     multi_o        more than one bit set
module keypad_prio16
    import keypad_scan4x4_pkg::*;
(
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        any_o,
    output logic        multi_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (vec_i[i] && !found) begin
                idx_o = 4'(i);
                found = 1'b1;
            end
        end
    end

    assign any_o   = |vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi_o = |(vec_i & (vec_i - 16'd1));

endmodule

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   presses/releases over whole scan frames and holds the accepted key in a
//   CPU-readable status word.
//   Ports:
//     clk           system clock
//     reset         asynchronous active-low reset
//     cs            read strobe; clears valid and overrun
//     i_row  [3:0]  keypad rows, active-low, asynchronous
//     o_col  [3:0]  column drive, active-low one-hot
//     o_data [31:0] {valid, overrun, multi, pressed-now, 24'b0, key[3:0]}
//     o_irq         mirrors valid
module keypad_scan4x4
    import keypad_scan4x4_pkg::*;
#(
    parameter int unsigned SCAN_DIV_W = 15,
    parameter int unsigned DB_FRAMES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [31:0] o_data,
    output logic        o_irq
);

    localparam logic [SCAN_DIV_W-1:0] PRESC_ONE = 1;
    localparam logic [3:0]            DB_N      = 4'(DB_FRAMES);

    logic [3:0]            row_meta_q, row_sync_q;
    logic [SCAN_DIV_W-1:0] presc_q;
    logic [1:0]            col_q;
    logic [3:0]            col_drv_q;
    logic [15:0]           frame_q;
    logic [15:0]           frame_cur;
    logic                  tick, frame_done;

    kp_state_e             state_q;
    logic [15:0]           cand_q;
    logic [3:0]            cnt_q, cnt_inc;
    logic [3:0]            key_q;
    logic                  multi_q, valid_q, ovr_q;
    logic                  accept;

    logic [3:0]            prio_idx;
    logic                  prio_any, prio_multi;

    // Two-flop synchronizer, prescaler and column scan
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            presc_q    <= '0;
            col_q      <= '0;
            col_drv_q  <= COL_SEL0;
            frame_q    <= '0;
        end else begin
            row_meta_q <= i_row;
            row_sync_q <= row_meta_q;
            presc_q    <= presc_q + PRESC_ONE;
            if (tick) begin
                // Sample on the last cycle of the dwell so rows have settled
                frame_q[{col_q, 2'b00} +: 4] <= ~row_sync_q;
                col_q     <= col_q + 2'd1;
                col_drv_q <= col_decode(col_q + 2'd1);
            end
        end
    end

    assign tick       = &presc_q;
    assign frame_done = tick && (col_q == 2'd3);
    assign o_col      = col_drv_q;

    // Column 3 is being sampled on the frame_done cycle, so splice it in
    always_comb begin
        frame_cur        = frame_q;
        frame_cur[15:12] = ~row_sync_q;
    end

    keypad_prio16 u_prio (
        .vec_i   (frame_cur),
        .idx_o   (prio_idx),
        .any_o   (prio_any),
        .multi_o (prio_multi)
    );

    assign cnt_inc = cnt_q + 4'd1;

    // A press is accepted either straight from IDLE (single-frame debounce)
    // or when the candidate has been seen for DB_FRAMES consecutive frames.
    assign accept = frame_done &&
                    (((state_q == ST_IDLE) && prio_any && (DB_N <= 4'd1)) ||
                     ((state_q == ST_PRESS_DB) && prio_any &&
                      (frame_cur == cand_q) && (cnt_inc >= DB_N)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (cs) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            // Acceptance overrides a simultaneous read; the old word counts as consumed
            if (accept) begin
                valid_q <= 1'b1;
                ovr_q   <= valid_q && !cs;
                key_q   <= prio_idx;
                multi_q <= prio_multi;
            end
            if (frame_done) begin
                case (state_q)
                    ST_IDLE: begin
                        if (prio_any) begin
                            cand_q  <= frame_cur;
                            cnt_q   <= 4'd1;
                            state_q <= accept ? ST_PRESSED : ST_PRESS_DB;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (!prio_any) begin
                            state_q <= ST_IDLE;
                        end else if (frame_cur == cand_q) begin
                            cnt_q <= cnt_inc;
                            if (accept) begin
                                state_q <= ST_PRESSED;
                            end
                        end else begin
                            cand_q <= frame_cur;
                            cnt_q  <= 4'd1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!prio_any) begin
                            cnt_q   <= 4'd1;
                            state_q <= (DB_N <= 4'd1) ? ST_IDLE : ST_REL_DB;
                        end
                    end
                    ST_REL_DB: begin
                        if (prio_any) begin
                            state_q <= ST_PRESSED;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc >= DB_N) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_data            = '0;
        o_data[VALID_BIT] = valid_q;
        o_data[OVR_BIT]   = ovr_q;
        o_data[MULTI_BIT] = multi_q;
        o_data[PRESS_BIT] = (state_q == ST_PRESSED) || (state_q == ST_REL_DB);
        o_data[3:0]       = key_q;
    end

    assign o_irq = valid_q;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb_keypad_scan4x4
//   Directed bench for keypad_scan4x4 with SCAN_DIV_W=2, DB_FRAMES=4
//   (4 clk per column, 16 clk per frame). A small keypad model pulls rows
//   low for any held key whose column is currently driven.
module tb_keypad_scan4x4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs    = 1'b0;
    logic [3:0]  i_row;
    logic [3:0]  o_col;
    logic [31:0] o_data;
    logic        o_irq;
    logic [15:0] keys  = '0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    keypad_scan4x4 #(
        .SCAN_DIV_W (2),
        .DB_FRAMES  (4)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .cs     (cs),
        .i_row  (i_row),
        .o_col  (o_col),
        .o_data (o_data),
        .o_irq  (o_irq)
    );

    // Keypad matrix: a held key shorts its row to its (active-low) column
    always_comb begin
        i_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4 + r] && !o_col[c]) begin
                    i_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    // Return at the negedge just after the column wraps back to 0
    task automatic align_frame();
        int k;
        k = 0;
        while (o_col !== 4'b1101 && k < 100) begin @(negedge clk); k++; end
        while (o_col !== 4'b1110 && k < 100) begin @(negedge clk); k++; end
        check("align_col0", {28'b0, o_col}, 32'h0000_000E);
    endtask

    task automatic pulse_cs();
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
    endtask

    initial begin
        logic [3:0] col_exp [4];
        int         n;
        logic       seen;

        col_exp[0] = 4'b1110;
        col_exp[1] = 4'b1101;
        col_exp[2] = 4'b1011;
        col_exp[3] = 4'b0111;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", o_data, 32'h0);
        check("rst_irq", {31'b0, o_irq}, 32'h0);
        check("rst_col", {28'b0, o_col}, 32'h0000_000E);

        // Idle scan: column advances every 4 clk
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i % 4 == 1) check("idle_col", {28'b0, o_col}, {28'b0, col_exp[(i + 1) / 4]});
        end
        check("idle_data", o_data, 32'h0);
        check("idle_irq", {31'b0, o_irq}, 32'h0);

        // Key 9 (col 2 / row 1) from a frame start
        align_frame();
        keys = 16'h0001 << 9;
        n = 0;
        while (!o_irq && n < 100) begin @(negedge clk); n++; end
        check("lat_in_window", {31'b0, (n >= 49 && n <= 67)}, 32'h1);
        check("k9_data", o_data, 32'h9000_0009);
        wait_frames(2);
        pulse_cs();
        check("k9_after_cs", o_data, 32'h1000_0009);
        keys = '0;
        wait_frames(6);
        check("k9_released", o_data, 32'h0000_0009);

        // Bouncing key 9: press / release / press, then held
        align_frame();
        seen = 1'b0;
        for (int f = 0; f < 3; f++) begin
            keys = (f == 1) ? 16'h0000 : (16'h0001 << 9);
            repeat (16) begin @(negedge clk); seen |= o_irq; end
        end
        check("bounce_no_valid", {31'b0, seen}, 32'h0);
        n = 0;
        while (!o_irq && n < 100) begin @(negedge clk); n++; end
        check("bounce_data", o_data, 32'h9000_0009);
        pulse_cs();
        seen = 1'b0;
        repeat (64) begin @(negedge clk); seen |= o_irq; end
        check("bounce_no_rereport", {31'b0, seen}, 32'h0);
        check("bounce_held", o_data, 32'h1000_0009);
        keys = '0;
        wait_frames(6);

        // Key 3 unread, then key 12 -> overrun
        keys = 16'h0001 << 3;
        wait_frames(6);
        check("k3_data", o_data, 32'h9000_0003);
        keys = '0;
        wait_frames(6);
        check("k3_released", o_data, 32'h8000_0003);
        keys = 16'h0001 << 12;
        wait_frames(6);
        check("k12_overrun", o_data, 32'hD000_000C);
        pulse_cs();
        check("k12_after_cs", o_data, 32'h1000_000C);
        keys = '0;
        wait_frames(6);

        // Keys 5 and 14 together -> lowest wins, multi set
        keys = (16'h0001 << 5) | (16'h0001 << 14);
        wait_frames(6);
        check("multi_data", o_data, 32'hB000_0005);
        pulse_cs();
        keys = '0;
        wait_frames(6);
        check("multi_released", o_data, 32'h2000_0005);

        // Reset in the middle of press debounce
        align_frame();
        keys = 16'h0001 << 9;
        wait_frames(2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", o_data, 32'h0);
        check("midrst_col", {28'b0, o_col}, 32'h0000_000E);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Frames complete on edges 16/32/48/64 after release
        repeat (48) @(negedge clk);
        check("midrst_not_early", {31'b0, o_irq}, 32'h0);
        repeat (15) @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        check("midrst_cs_accept", o_data, 32'h9000_0009);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan4x4.md
Name: keypad_scan4x4

Overview:
- Memory-mapped input peripheral that scans a 4x4 matrix keypad.
- Drives one active-low column at a time and samples the four active-low rows, mirroring the time-multiplexed style of the display driver.
- Debounces each press, encodes it as a 4-bit key index and holds it in a status word that the CPU reads over the same cs/data bus style as the display.
- Sits on the IO bus beside the 7-segment display driver.

Parameters:
- SCAN_DIV_W, 15, prescaler width; the column advances every 2^SCAN_DIV_W clk cycles (benches use 2).
- DB_FRAMES, 4, number of consecutive identical full-scan frames required to accept a press or a release (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cs  input  1  read-acknowledge strobe; a one-cycle pulse clears the valid and overrun flags.
- i_row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- o_col  output  4  column drive, active-low one-hot.
- o_data  output  32  status word: [31] valid, [30] overrun, [29] multi, [28] pressed-now, [27:4] zero, [3:0] key index.
- o_irq  output  1  equals valid.

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, column index=0, o_col=4'b1110, synchronizer=4'hF, frame=0, FSM=IDLE, debounce count=0, key=0. All of o_data, including the flag bits, is 0. o_irq=0.
- Synchronizer: i_row passes through 2 flops before any use.
- Prescaler:
  - Free-running counter, SCAN_DIV_W bits wide; tick = (counter == all ones).
  - On a tick: capture ~row_sync into frame[col*4 +: 4], then col <= col+1, wrapping 3->0.
  - o_col is registered and decoded from col: 0->1110, 1->1101, 2->1011, 3->0111.
  - Sampling on the last cycle of a dwell gives the rows a full dwell to settle.
- Frame completion:
  - frame_done pulses on the tick where col==3.
  - The completed 16-bit frame is compared against the previous frame.
  - Key index = col*4 + row of the lowest set frame bit (bit n -> index n).
  - multi = more than one bit set.
- FSM (advances only on frame_done):
  - IDLE: a non-empty frame -> load candidate=frame, cnt=1, go to PRESS_DB.
  - PRESS_DB:
    - Frame equal to candidate -> cnt++.
    - Frame differs and is non-empty -> reload candidate, cnt=1.
    - Frame empty -> IDLE.
    - When cnt reaches DB_FRAMES -> go to PRESSED. In the same cycle, latch key index and multi, and set valid. If valid was already 1 at that moment, also set overrun.
  - PRESSED: an empty frame -> cnt=1, go to REL_DB. Any other change is ignored; no re-report.
  - REL_DB:
    - Empty frame -> cnt++.
    - Non-empty frame -> PRESSED.
    - When cnt reaches DB_FRAMES -> IDLE.
  - DB_FRAMES=1: the transition happens on the first qualifying frame.
- pressed-now = 1 in PRESSED and REL_DB.
- Latency:
  - A press stable from a frame start is reported DB_FRAMES frames later (frame = 4*2^SCAN_DIV_W cycles), plus synchronizer delay.
  - valid rises on the clk edge after the final frame_done.
- Read handshake:
  - o_data is a combinational view of the status registers.
  - cs=1 clears valid and overrun on the next edge; key, multi and pressed-now are unaffected.
  - If cs and a new acceptance occur in the same cycle, the acceptance wins: valid=1, new key, overrun=0, because the old value was consumed.
  - cs while valid=0 has no effect.
- Reset mid-scan or mid-debounce returns everything to the reset state immediately; no partial report is produced.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, PRESS_DB, PRESSED, REL_DB.
  - o_data bit-position constants (VALID_BIT=31, OVR_BIT=30, MULTI_BIT=29, PRESS_BIT=28).
  - The column one-hot decode constants, also reusable by the display driver's select logic.
- One natural sub-module: keypad_prio16, a combinational 16-bit lowest-set-bit encoder producing a 4-bit index plus any and multi flags.
- The scan counter and FSM stay in the top module.

Test Plan (SCAN_DIV_W=2, DB_FRAMES=4; frame = 16 clk):
- Reset released, no key pressed -> o_col cycles 1110, 1101, 1011, 0111 every 4 clk; o_data stays 32'h0 and o_irq stays 0.
- Key at col 2 / row 1 held for 6 frames -> o_data = 32'h9000_0009 (valid and pressed-now set) within 4 frames plus 3 clk, and not before frame 4. Pulse cs -> o_data = 32'h1000_0009 while held.
- Same key bounces (toggled every frame for 3 frames, then held) -> exactly one report, key=9; valid never pulses during the bounce phase.
- Press key 3 without reading, release, then press key 12 -> o_data = 32'hD000_000C (valid, overrun, pressed-now). One cs -> 32'h1000_000C.
- Keys 5 and 14 pressed together -> key=5, multi=1, o_data = 32'hB000_0005.
- Assert reset mid-PRESS_DB (after 2 frames) -> o_data=0 and o_col=1110 immediately. After release of reset with the key still held, a full DB_FRAMES debounce is needed before valid=1; cs asserted in the same cycle as acceptance still leaves valid=1.
